// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ifu_pkg;

  localparam int unsigned IFU_XLEN       = 32;
  localparam logic [3:0]  IMEM_MASK_WORD = 4'b1111;
  localparam int unsigned PC_STEP        = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } ifu_state_e;

  // Default queue entry for RV32: fetched instruction plus its PC.
  typedef struct packed {
    logic [IFU_XLEN-1:0] instr;
    logic [IFU_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetch entries with flush. Registered output, no bypass.
module instr_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     din,
  output entry_t                     dout,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  entry_t          mem [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush drops every entry at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PtrW'(1);
      if (do_push && !do_pop)      count <= count + CntW'(1);
      else if (!do_push && do_pop) count <= count - CntW'(1);
    end
  end

endmodule

// File: rtl/prefetch_ifu.sv
// RV32I fetch unit: pipelined imem requests, in-order prefetch queue toward
// decode, redirect flush with stale-response discard.
module prefetch_ifu
  import ifu_pkg::*;
#(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          Depth       = 4,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  input  logic                 imem_gnt,
  output logic [AddrWidth-1:0] imem_addr,
  output logic                 imem_we_re,
  output logic [3:0]           imem_mask,
  input  logic                 imem_valid,
  input  logic [DataWidth-1:0] imem_rdata,
  input  logic                 redirect,
  input  logic [AddrWidth-1:0] redirect_addr,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [DataWidth-1:0] dec_instr,
  output logic [AddrWidth-1:0] dec_pc
);

  localparam int unsigned  CntW    = $clog2(Depth+1);
  localparam logic [CntW:0] DEPTH_W = (CntW+1)'(Depth);

  typedef struct packed {
    logic [DataWidth-1:0] instr;
    logic [AddrWidth-1:0] pc;
  } entry_t;

  ifu_state_e           state, state_nxt;
  logic [AddrWidth-1:0] fetch_pc, resp_pc, redirect_pc;
  logic [CntW-1:0]      outstanding, outstanding_nxt, discard, discard_nxt, count;
  logic [CntW:0]        in_use;
  logic                 accept, resp, take_redirect, push, pop;
  logic                 fifo_full, fifo_empty;
  entry_t               push_entry, head_entry;

  assign imem_we_re  = 1'b0;
  assign imem_mask   = IMEM_MASK_WORD;
  assign imem_addr   = fetch_pc;
  assign redirect_pc = redirect_addr & ~AddrWidth'(3);

  // Credit: queued entries plus in-flight requests never exceed Depth,
  // so every response has a guaranteed queue slot.
  assign in_use   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req = (state == RUN) && (in_use < DEPTH_W);

  assign accept          = imem_req && imem_gnt;
  assign resp            = imem_valid && (outstanding != '0);
  assign take_redirect   = redirect && (state != BOOT);
  assign outstanding_nxt = outstanding + CntW'(accept) - CntW'(resp);
  assign pop             = dec_valid && dec_ready && !take_redirect;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = resp_pc;
  assign dec_valid        = !fifo_empty;
  assign dec_instr        = head_entry.instr;
  assign dec_pc           = head_entry.pc;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  // Next state, discard bookkeeping and push; a redirect overrides all of it.
  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    push        = 1'b0;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN:  push = resp;
      FLUSH: begin
        if (resp) discard_nxt = discard - CntW'(1);
        if (discard_nxt == '0) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
    if (take_redirect) begin
      // Anything still in flight after this edge, including a request
      // accepted right now, belongs to the old path.
      push        = 1'b0;
      discard_nxt = outstanding_nxt;
      state_nxt   = (outstanding_nxt == '0) ? RUN : FLUSH;
    end
  end

  // PCs and in-flight counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= ResetVector;
      resp_pc     <= ResetVector;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (take_redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (accept) fetch_pc <= fetch_pc + AddrWidth'(PC_STEP);
        if (push)   resp_pc  <= resp_pc + AddrWidth'(PC_STEP);
      end
    end
  end

  instr_fifo #(
    .Depth   (Depth),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (take_redirect),
    .din   (push_entry),
    .dout  (head_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && fifo_full && !pop));
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    !(imem_valid && outstanding == '0));

endmodule

// File: tb/tb_prefetch_ifu.sv
// Bench for prefetch_ifu: latency-programmable in-order memory model and a
// scoreboard of expected {pc, instr} pairs checked at each decode handshake.
module tb_prefetch_ifu;

  localparam logic [31:0] RV = 32'h0;

  logic        clk = 1'b0, rst = 1'b0;
  logic        imem_req, imem_we_re, dec_valid;
  logic        imem_gnt = 1'b0, imem_valid = 1'b0, redirect = 1'b0, dec_ready = 1'b0;
  logic [31:0] imem_addr, dec_instr, dec_pc;
  logic [31:0] imem_rdata = '0, redirect_addr = '0;
  logic [3:0]  imem_mask;

  prefetch_ifu #(
    .DataWidth(32), .AddrWidth(32), .Depth(4), .ResetVector(RV)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
    .imem_we_re(imem_we_re), .imem_mask(imem_mask),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct packed { logic [31:0] data; int due; } rsp_t;

  exp_t        sb_q[$];
  rsp_t        mem_q[$];
  exp_t        e;
  int          n_tests = 0, n_fail = 0;
  int          ncyc = 0, lat = 1, n_accept = 0, n_deliv = 0;
  int          first_valid = -1, first_dec = -1;
  logic [31:0] first_acc_addr = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Inputs change at negedge+1; this process runs at negedge+3 so it sees
  // final values for the coming posedge.
  always @(negedge clk) begin
    #3;
    ncyc++;
    if (rst) begin
      if (dec_valid && first_dec < 0) first_dec = ncyc;
      if (dec_valid && dec_ready) begin
        n_deliv++;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra got pc=%h instr=%h, expected nothing", dec_pc, dec_instr);
        end else begin
          e = sb_q.pop_front();
          if (dec_pc !== e.pc || dec_instr !== e.instr) begin
            n_fail++;
            $display("FAIL sb_entry got pc=%h instr=%h exp pc=%h instr=%h",
                     dec_pc, dec_instr, e.pc, e.instr);
          end
        end
      end
    end
    if (mem_q.size() > 0 && mem_q[0].due <= ncyc) begin
      imem_valid = 1'b1;
      imem_rdata = mem_q[0].data;
      void'(mem_q.pop_front());
      if (first_valid < 0) first_valid = ncyc;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = '0;
    end
    if (rst && imem_req && imem_gnt) begin
      if (n_accept == 0) first_acc_addr = imem_addr;
      mem_q.push_back('{data: mem_data(imem_addr), due: ncyc + lat});
      n_accept++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      sb_q.push_back('{pc: base + 32'(4*i), instr: mem_data(base + 32'(4*i))});
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0; imem_gnt = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
    redirect_addr = '0; imem_valid = 1'b0; lat = 1;
    mem_q.delete(); sb_q.delete();
    n_accept = 0; n_deliv = 0; first_valid = -1; first_dec = -1;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    rst = 1'b0; imem_gnt = 1'b1; mem_q.delete(); sb_q.delete(); n_accept = 0;
    cyc(2);
    n_tests++; if (imem_req !== 1'b0)  begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid got=%b exp=0", dec_valid); end
    n_tests++; if (imem_addr !== RV)   begin n_fail++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RV); end
    n_tests++; if (dec_instr !== '0 || dec_pc !== '0) begin
      n_fail++; $display("FAIL rst_dec_data got instr=%h pc=%h exp 0/0", dec_instr, dec_pc); end
    n_tests++; if (imem_we_re !== 1'b0 || imem_mask !== 4'hF) begin
      n_fail++; $display("FAIL rst_ties got we=%b mask=%h exp 0/f", imem_we_re, imem_mask); end
    rst = 1'b1;
    #3;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req got=%b exp=0", imem_req); end
    cyc(1);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== RV) begin
      n_fail++; $display("FAIL first_req got req=%b addr=%h exp 1/%h", imem_req, imem_addr, RV); end
  endtask

  task automatic test_stream();
    int d0;
    do_reset();
    push_stream(RV, 64);
    imem_gnt = 1'b1; dec_ready = 1'b1;
    cyc(8);
    d0 = n_deliv;
    cyc(10);
    n_tests++; if (n_deliv - d0 !== 10) begin
      n_fail++; $display("FAIL throughput got=%0d exp=10 in 10 cycles", n_deliv - d0); end
    n_tests++; if (first_valid < 0 || first_dec !== first_valid + 1) begin
      n_fail++; $display("FAIL dec_latency got dec_cyc=%0d exp=%0d", first_dec, first_valid + 1); end
  endtask

  task automatic test_credit();
    int a1;
    do_reset();
    push_stream(RV, 16);
    imem_gnt = 1'b1;
    cyc(15);
    n_tests++; if (n_accept !== 4) begin n_fail++; $display("FAIL credit_accepts got=%0d exp=4", n_accept); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL credit_req got=%b exp=0", imem_req); end
    a1 = n_accept;
    dec_ready = 1'b1;
    cyc(1);
    dec_ready = 1'b0;
    cyc(8);
    n_tests++; if (n_accept - a1 !== 1) begin
      n_fail++; $display("FAIL credit_refill got=%0d exp=1", n_accept - a1); end
    n_tests++; if (n_deliv !== 1) begin n_fail++; $display("FAIL credit_pops got=%0d exp=1", n_deliv); end
  endtask

  task automatic test_redirect_flush();
    int n0;
    do_reset();
    lat = 4; imem_gnt = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 30 && n_accept < 3; i++) begin @(negedge clk); #4; end
    n_tests++; if (n_accept !== 3) begin n_fail++; $display("FAIL flush_setup got accepts=%0d exp=3", n_accept); end
    cyc(1);
    imem_gnt = 1'b0; redirect = 1'b1; redirect_addr = 32'h100;
    sb_q.delete(); push_stream(32'h100, 32);
    cyc(1);
    redirect = 1'b0; imem_gnt = 1'b1;
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dec_valid got=%b exp=0", dec_valid); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req cyc%0d got=%b exp=0", i, imem_req); end
      if (i < 2) cyc(1);
    end
    cyc(1);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL flush_restart got req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
    n0 = n_deliv;
    cyc(20);
    n_tests++; if (n_deliv - n0 < 4) begin n_fail++; $display("FAIL flush_deliv got=%0d exp>=4", n_deliv - n0); end
  endtask

  task automatic test_redirect_collide();
    bit hit = 1'b0;
    int n0;
    do_reset();
    imem_gnt = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk); #4;
      hit = imem_req && imem_gnt && imem_valid;
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL collide_setup got no accept+response cycle, exp one"); end
    redirect = 1'b1; redirect_addr = 32'h40;
    sb_q.delete(); push_stream(32'h40, 32);
    cyc(1);
    redirect = 1'b0; dec_ready = 1'b1;
    n_tests++; if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL collide_flush got dec_valid=%b req=%b exp 0/0", dec_valid, imem_req); end
    cyc(1);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL collide_restart got req=%b addr=%h exp 1/00000040", imem_req, imem_addr); end
    n0 = n_deliv;
    cyc(10);
    n_tests++; if (n_deliv - n0 < 5) begin n_fail++; $display("FAIL collide_deliv got=%0d exp>=5", n_deliv - n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    do_reset();
    lat = 4; imem_gnt = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 30 && n_accept < 2; i++) begin @(negedge clk); #4; end
    n_tests++; if (n_accept < 2) begin n_fail++; $display("FAIL b2b_setup got accepts=%0d exp>=2", n_accept); end
    cyc(1);
    redirect = 1'b1; redirect_addr = 32'h200;
    sb_q.delete(); push_stream(32'h200, 32);
    cyc(1);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_in_flush got req=%b exp=0", imem_req); end
    redirect_addr = 32'h302;
    sb_q.delete(); push_stream(32'h300, 32);
    cyc(1);
    redirect = 1'b0;
    n0 = n_deliv;
    cyc(25);
    n_tests++; if (n_deliv - n0 < 6) begin n_fail++; $display("FAIL b2b_deliv got=%0d exp>=6", n_deliv - n0); end
  endtask

  task automatic test_rst_mid();
    int n0;
    do_reset();
    push_stream(RV, 64);
    imem_gnt = 1'b1; dec_ready = 1'b1;
    cyc(8);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ctrl got req=%b dec_valid=%b exp 0/0", imem_req, dec_valid); end
    n_tests++; if (imem_addr !== RV || dec_instr !== '0 || dec_pc !== '0) begin
      n_fail++; $display("FAIL mid_rst_data got addr=%h instr=%h pc=%h exp %h/0/0", imem_addr, dec_instr, dec_pc, RV); end
    imem_valid = 1'b0; mem_q.delete(); sb_q.delete(); n_accept = 0;
    @(negedge clk); #1;
    rst = 1'b1;
    push_stream(RV, 64);
    n0 = n_deliv;
    cyc(12);
    n_tests++; if (n_accept == 0 || first_acc_addr !== RV) begin
      n_fail++; $display("FAIL mid_rst_restart got accepts=%0d addr=%h exp addr=%h", n_accept, first_acc_addr, RV); end
    n_tests++; if (n_deliv - n0 < 8) begin n_fail++; $display("FAIL mid_rst_deliv got=%0d exp>=8", n_deliv - n0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_redirect_flush();
    test_redirect_collide();
    test_back_to_back();
    test_rst_mid();
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_ifu.md
# prefetch_ifu

Parametrised RV32I instruction fetch unit with an in-order prefetch queue. It sits between the instruction memory port and the decode stage. It replaces the single-shot pass-through fetch with pipelined memory requests, up to `Depth` in flight, and a buffered PC/instruction queue with a valid/ready handshake toward decode. Branch and jump redirects flush the queue and discard stale in-flight responses.

## Interface
- `DataWidth`, default 32: instruction width.
- `AddrWidth`, default 32: PC and address width.
- `Depth`, default 4: queue entries and maximum outstanding requests. Must be a power of two and ≥2.
- `ResetVector`, default 0: first fetch address after reset.

Ports, clock and reset first:
- `clk`, in, 1: single clock. All state is rising-edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `imem_req`, out, 1: fetch request valid.
- `imem_gnt`, in, 1: memory accepts the request. A request transfers when `imem_req & imem_gnt`.
- `imem_addr`, out, AddrWidth: fetch address, word-aligned.
- `imem_we_re`, out, 1: tied 0 (read).
- `imem_mask`, out, 4: tied 4'b1111.
- `imem_valid`, in, 1: response data valid. Responses return in request order.
- `imem_rdata`, in, DataWidth: response instruction.
- `redirect`, in, 1: taken branch, jal or jalr from execute.
- `redirect_addr`, in, AddrWidth: new PC. Bits [1:0] are ignored and forced to 0.
- `dec_valid`, out, 1: queue head valid.
- `dec_ready`, in, 1: decode consumes the head when `dec_valid & dec_ready`.
- `dec_instr`, out, DataWidth: head instruction.
- `dec_pc`, out, AddrWidth: PC of the head instruction.

## Operation
Registers:
- `fetch_pc`: next request address.
- `resp_pc`: PC of the next accepted response.
- `outstanding`: requests in flight, width `$clog2(Depth+1)`.
- `discard`: stale responses still to drop.
- `count`: queue occupancy.

FSM states:
- BOOT: one cycle after reset release, `imem_req`=0. Always goes to RUN.
- RUN: `imem_req = (count + outstanding < Depth)`.
  - On accept: `fetch_pc += 4` and `outstanding++`.
  - On `imem_valid`: `outstanding--`, push {`imem_rdata`, `resp_pc`}, and `resp_pc += 4`.
  - Accept and response in the same cycle leave `outstanding` unchanged.
- FLUSH: entered on a redirect when the post-redirect in-flight count is nonzero. `imem_req`=0. Each `imem_valid` decrements `outstanding` and `discard` and pushes nothing. Go to RUN when `discard` reaches 0. A redirect received while in FLUSH retargets the PCs and recomputes `discard`.

Redirect, in any state except BOOT, takes effect in that cycle's edge:
- Clear the queue: `count`=0.
- `fetch_pc` and `resp_pc` are set to `redirect_addr`.
- `discard` = `outstanding` + (accept this cycle) − (`imem_valid` this cycle).
- Go to RUN if `discard`=0, otherwise FLUSH.
- A request accepted in the redirect cycle is counted as stale.

Priority and boundary rules:
- Redirect beats push and pop in the same cycle.
- Push and pop in the same cycle leave `count` unchanged.
- Full queue: the credit rule guarantees no overflow. A push while `count`=Depth is an assertion failure.
- `imem_valid` while `outstanding`=0 is ignored and flagged by an assertion.
- `fetch_pc` wraps modulo 2^AddrWidth.
- Asserting `rst` mid-operation abandons all in-flight requests. Memory is responsible for quiescing.

## Timing
Reset values:
- `imem_req`=0, `dec_valid`=0.
- `imem_addr`=`ResetVector`, `dec_instr`=0, `dec_pc`=0.
- `count`=`outstanding`=`discard`=0.
- State BOOT.

Latency and throughput:
- First `imem_req` is in the 2nd cycle after `rst` deasserts.
- `imem_req` and `imem_addr` are combinational from registers only, never from `imem_gnt`.
- Queue is registered with no bypass: `imem_valid` at edge N gives `dec_valid` after edge N.
- Redirect at edge N: `dec_valid`=0 after N. The new request issues in cycle N+1 if `discard`=0.
- Throughput is 1 instruction/cycle with a zero-wait memory and continuous `dec_ready`.

## Structure
- Shared package `ifu_pkg` holds:
  - `ifu_state_e` {BOOT, RUN, FLUSH}.
  - The queue entry struct `fetch_entry_t` {instr, pc}.
  - Constants `IMEM_MASK_WORD` = 4'b1111 and `PC_STEP` = 4.
- One sub-module, `instr_fifo`: synchronous FIFO of `fetch_entry_t`, parametrised by `Depth`, with push, pop, flush, count, full and empty.

## Test plan
1. Reset release, `imem_gnt`=1, zero-wait memory → requests to addresses 0x0, 0x4, 0x8, …; `dec_valid` rises 1 cycle after the first `imem_valid`; 1 instruction per cycle.
2. `dec_ready`=0 with `Depth`=4 → at most 4 requests issue and `imem_req` drops. Popping one entry lets exactly one new request issue.
3. Redirect to 0x100 with 3 requests outstanding → queue empties and 3 responses are dropped in FLUSH. The next `dec_pc`=0x100 with the matching instruction.
4. Redirect in a cycle with both an accept and a response → `discard` equals the old `outstanding`. No stale instruction reaches decode.
5. Back-to-back redirects (0x200, then 0x300 during FLUSH) → only instructions from 0x300 onward are delivered.
6. `rst` asserted mid-stream → all outputs return to reset values asynchronously. After release, fetch restarts at `ResetVector`.
